// File: rtl/mod_dlog_search.sv
// Discrete-log solver: finds the smallest b with (a^b) mod n == y by stepping
// the running residue r = a^k mod n once per clock, k ascending from 0.
module mod_dlog_search #(
    parameter int W       = 8,
    parameter int MAX_EXP = (1 << W) - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] y,
    input  logic [W-1:0] n,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic         err,
    output logic [W-1:0] exp_out
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SEARCH = 1'b1
    } state_t;

    localparam logic [W-1:0] ZERO_W = {W{1'b0}};
    localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MAX_K  = W'(MAX_EXP);

    // Full 2W-bit product reduced by the latched modulus; a zero modulus
    // only occurs while idle, so the divisor guard never affects a result.
    function automatic logic [W-1:0] mul_mod(input logic [W-1:0] x,
                                             input logic [W-1:0] m,
                                             input logic [W-1:0] md);
        logic [2*W-1:0] prod;
        logic [2*W-1:0] div;
        prod = {ZERO_W, x} * {ZERO_W, m};
        div  = (md == ZERO_W) ? {ZERO_W, ONE_W} : {ZERO_W, md};
        mul_mod = W'(prod % div);
    endfunction

    state_t       state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] y_q, y_d;
    logic [W-1:0] n_q, n_d;
    logic [W-1:0] r_q, r_d;
    logic [W-1:0] k_q, k_d;
    logic [W-1:0] exp_q, exp_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         found_q, found_d;
    logic         err_q, err_d;

    // Next-state and output computation for the accept/search sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        y_d     = y_q;
        n_d     = n_q;
        r_d     = r_q;
        k_d     = k_q;
        exp_d   = exp_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        found_d = found_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    found_d = 1'b0;
                    exp_d   = ZERO_W;
                    if (n == ZERO_W) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        a_d     = a;
                        y_d     = y;
                        n_d     = n;
                        r_d     = (n == ONE_W) ? ZERO_W : ONE_W;
                        k_d     = ZERO_W;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_SEARCH;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEARCH: begin
                if (r_q == y_q) begin
                    found_d = 1'b1;
                    exp_d   = k_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (k_q == MAX_K) begin
                    found_d = 1'b0;
                    exp_d   = ZERO_W;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    r_d = mul_mod(r_q, a_q, n_q);
                    k_d = k_q + ONE_W;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= ZERO_W;
            y_q     <= ZERO_W;
            n_q     <= ZERO_W;
            r_q     <= ZERO_W;
            k_q     <= ZERO_W;
            exp_q   <= ZERO_W;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            y_q     <= y_d;
            n_q     <= n_d;
            r_q     <= r_d;
            k_q     <= k_d;
            exp_q   <= exp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            found_q <= found_d;
            err_q   <= err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign found   = found_q;
    assign err     = err_q;
    assign exp_out = exp_q;

endmodule

// File: tb/tb_mod_dlog_search.sv
// Self-checking bench for mod_dlog_search: directed cases plus randomized
// searches compared against an arithmetic discrete-log reference.
module tb_mod_dlog_search;

    localparam int W       = 8;
    localparam int MAX_EXP = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a, y, n;
    logic         busy, done, found, err;
    logic [W-1:0] exp_out;

    int tests_run;
    int tests_failed;

    mod_dlog_search #(.W(W), .MAX_EXP(MAX_EXP)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .y       (y),
        .n       (n),
        .busy    (busy),
        .done    (done),
        .found   (found),
        .err     (err),
        .exp_out (exp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Smallest b in [0, MAX_EXP] with a^b mod n == y.
    function automatic void ref_dlog(input int ra, input int ry, input int rn,
                                     output bit f, output int e, output bit er);
        int p;
        f = 1'b0; e = 0; er = 1'b0;
        if (rn == 0) begin
            er = 1'b1;
            return;
        end
        p = 1 % rn;
        for (int b = 0; b <= MAX_EXP; b++) begin
            if (p == ry) begin
                f = 1'b1;
                e = b;
                return;
            end
            p = (p * ra) % rn;
        end
    endfunction

    function automatic int pow_mod(input int ra, input int b, input int rn);
        int p;
        p = 1 % rn;
        for (int i = 0; i < b; i++) p = (p * ra) % rn;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one search from idle and checks latency and results.
    task automatic run_one(input logic [W-1:0] ta, input logic [W-1:0] ty,
                           input logic [W-1:0] tn, input bit disturb);
        bit ef, eer, got;
        int ee, lat, cnt;
        ref_dlog(int'(ta), int'(ty), int'(tn), ef, ee, eer);
        lat = ef ? ee + 1 : MAX_EXP + 1;
        a = ta; y = ty; n = tn; start = 1'b1;
        tick();
        start = 1'b0;
        if (eer) begin
            chk_eq("nzero_done", done, 1);
            chk_eq("nzero_err", err, 1);
            chk_eq("nzero_found", found, 0);
            chk_eq("nzero_busy", busy, 0);
        end else begin
            chk_eq("accept_busy", busy, 1);
            chk_eq("accept_done", done, 0);
            cnt = 0;
            got = 1'b0;
            while (!got && cnt < MAX_EXP + 10) begin
                if (disturb) begin
                    start = 1'($urandom_range(0, 1));
                    a = W'($urandom); y = W'($urandom); n = W'($urandom);
                end
                tick();
                cnt++;
                if (done) got = 1'b1;
            end
            start = 1'b0;
            chk_eq("done_seen", got, 1);
            chk_eq("latency", cnt, lat);
            chk_eq("found", found, ef);
            chk_eq("exp_out", exp_out, ee);
            chk_eq("err", err, 0);
            chk_eq("busy_end", busy, 0);
        end
        tick();
        chk_eq("done_one_cycle", done, 0);
        chk_eq("hold_busy", busy, 0);
        chk_eq("hold_found", found, ef);
        chk_eq("hold_err", err, eer);
        chk_eq("hold_exp", exp_out, ee);
    endtask

    initial begin
        int ra, rn, ry;
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1; start = 1'b0; a = '0; y = '0; n = '0;
        tick();
        tick();
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_done", done, 0);
        chk_eq("rst_found", found, 0);
        chk_eq("rst_err", err, 0);
        chk_eq("rst_exp", exp_out, 0);
        rst = 1'b0;
        tick();

        run_one(8'd3, 8'd13, 8'd17, 1'b0);
        run_one(8'd2, 8'd3, 8'd7, 1'b0);
        run_one(8'd5, 8'd1, 8'd11, 1'b0);
        run_one(8'd9, 8'd0, 8'd1, 1'b0);
        run_one(8'd7, 8'd4, 8'd0, 1'b0);
        run_one(8'd4, 8'd20, 8'd17, 1'b0);
        run_one(8'd3, 8'd13, 8'd17, 1'b1);

        // Start pulse with other operands at k=2 must be ignored.
        a = 8'd3; y = 8'd13; n = 8'd17; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'd2; y = 8'd1; n = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk_eq("ignore_done", done, 1);
        chk_eq("ignore_found", found, 1);
        chk_eq("ignore_exp", exp_out, 4);
        tick();

        // Reset mid-search at k=2.
        a = 8'd3; y = 8'd13; n = 8'd17; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_eq("mrst_busy", busy, 0);
        chk_eq("mrst_done", done, 0);
        chk_eq("mrst_found", found, 0);
        chk_eq("mrst_exp", exp_out, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_eq("mrst_no_done", done, 0);
        end
        run_one(8'd3, 8'd13, 8'd17, 1'b0);

        for (int t = 0; t < 24; t++) begin
            rn = (t % 6 == 0) ? $urandom_range(0, 2) : $urandom_range(2, 255);
            ra = $urandom_range(0, 255);
            if (rn != 0 && t % 2 == 0) ry = pow_mod(ra, $urandom_range(0, 40), rn);
            else ry = $urandom_range(0, 255);
            run_one(W'(ra), W'(ry), W'(rn), t % 3 == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
